// File: rtl/bip_pkg.sv
// Shared BIP definitions: instruction field widths, HLT opcode, loader start byte, loader FSM states.
// The CHECK state exists only when BIP_LOADER_CHECKSUM_EN is defined.
package bip_pkg;
  localparam int                   NB_OPCODE  = 5;
  localparam int                   NB_OPERAND = 11;
  localparam logic [NB_OPCODE-1:0] HLT_OPCODE = 5'b00000;
  localparam logic [7:0]           START_BYTE = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_LO = 3'd1,
    S_LOAD_HI = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
`ifdef BIP_LOADER_CHECKSUM_EN
    ,
    S_CHECK   = 3'd5
`endif
  } loader_state_t;

  function automatic logic is_hlt(input logic [NB_OPCODE-1:0] opcode);
    return opcode == HLT_OPCODE;
  endfunction
endpackage

// File: rtl/bip_prog_loader.sv
// BIP program loader: assembles UART bytes into instructions, writes program memory and holds
// the core in reset until HLT is stored. Optional trailing checksum byte: BIP_LOADER_CHECKSUM_EN.
module bip_prog_loader #(
  parameter int                 NB_BYTE    = 8,
  parameter int                 NB_INSTR   = bip_pkg::NB_OPCODE + bip_pkg::NB_OPERAND,
  parameter int                 NB_ADDR    = 11,
  parameter int                 NB_OPCODE  = bip_pkg::NB_OPCODE,
  parameter logic [NB_BYTE-1:0] START_BYTE = bip_pkg::START_BYTE
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic [NB_ADDR-1:0]  o_pmem_addr,
  output logic [NB_INSTR-1:0] o_pmem_data,
  output logic                o_pmem_we,
  output logic                o_cpu_reset,
  output logic                o_cpu_enable,
  output logic                o_loading,
  output logic                o_overflow,
  output logic [NB_ADDR:0]    o_word_count
`ifdef BIP_LOADER_CHECKSUM_EN
  ,
  output logic                o_chk_error
`endif
);
  import bip_pkg::*;

  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_ONE   = {{NB_ADDR{1'b0}}, 1'b1};

  loader_state_t       state_r, state_s;
  logic [NB_ADDR-1:0]  addr_r, addr_s;
  logic [NB_INSTR-1:0] instr_r, instr_s;
  logic [NB_ADDR:0]    count_r, count_s;
  logic                we_r, we_s;
  logic                cpu_reset_r, cpu_reset_s;
  logic                cpu_enable_r, cpu_enable_s;
  logic                loading_r, loading_s;
  logic                overflow_r, overflow_s;
  logic                start_s;
  logic                hold_s;
  logic                release_s;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]  csum_r, csum_s;
  logic                chk_error_r, chk_error_s;
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    instr_s    = instr_r;
    count_s    = count_r;
    overflow_s = overflow_r;
    we_s       = 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
    csum_s      = csum_r;
    chk_error_s = chk_error_r;
    hold_s      = overflow_r | chk_error_r;
`else
    hold_s      = overflow_r;
`endif
    start_s = i_rx_valid && (i_rx_data == START_BYTE);

    case (state_r)
      S_IDLE: begin
        addr_s     = {NB_ADDR{1'b0}};
        count_s    = {(NB_ADDR+1){1'b0}};
        overflow_s = 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
        csum_s      = {NB_BYTE{1'b0}};
        chk_error_s = 1'b0;
`endif
        if (start_s) state_s = S_LOAD_LO;
        else         state_s = S_IDLE;
      end
      S_LOAD_LO: begin
        if (i_rx_valid) begin
          instr_s[NB_BYTE-1:0] = i_rx_data;
`ifdef BIP_LOADER_CHECKSUM_EN
          csum_s = csum_r ^ i_rx_data;
`endif
          state_s = S_LOAD_HI;
        end else begin
          state_s = S_LOAD_LO;
        end
      end
      S_LOAD_HI: begin
        if (i_rx_valid) begin
          instr_s[NB_INSTR-1:NB_BYTE] = i_rx_data;
`ifdef BIP_LOADER_CHECKSUM_EN
          csum_s = csum_r ^ i_rx_data;
`endif
          we_s    = 1'b1;
          count_s = count_r + CNT_ONE;
          state_s = S_WRITE;
        end else begin
          state_s = S_LOAD_HI;
        end
      end
      S_WRITE: begin
        // Any byte arriving here is dropped.
        if (is_hlt(instr_r[NB_INSTR-1 -: NB_OPCODE])) begin
`ifdef BIP_LOADER_CHECKSUM_EN
          state_s = S_CHECK;
`else
          state_s = S_DONE;
`endif
        end else if (addr_r == ADDR_LAST) begin
          overflow_s = 1'b1;
          state_s    = S_DONE;
        end else begin
          addr_s  = addr_r + ADDR_ONE;
          state_s = S_LOAD_LO;
        end
      end
`ifdef BIP_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_valid) begin
          chk_error_s = (i_rx_data != csum_r);
          state_s     = S_DONE;
        end else begin
          state_s = S_CHECK;
        end
      end
`endif
      S_DONE: begin
        if (start_s) begin
          addr_s     = {NB_ADDR{1'b0}};
          count_s    = {(NB_ADDR+1){1'b0}};
          overflow_s = 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
          csum_s      = {NB_BYTE{1'b0}};
          chk_error_s = 1'b0;
`endif
          state_s = S_LOAD_LO;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase

    // The core leaves reset after the first DONE cycle and runs one cycle after that.
    release_s    = (state_r == S_DONE) && (state_s == S_DONE) && !hold_s;
    cpu_reset_s  = !release_s;
    cpu_enable_s = release_s && !cpu_reset_r;
    loading_s    = (state_s == S_LOAD_LO) || (state_s == S_LOAD_HI) || (state_s == S_WRITE);
  end

  // State and output registers; asynchronous reset returns to idle with the core held.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= S_IDLE;
      addr_r       <= {NB_ADDR{1'b0}};
      instr_r      <= {NB_INSTR{1'b0}};
      count_r      <= {(NB_ADDR+1){1'b0}};
      we_r         <= 1'b0;
      cpu_reset_r  <= 1'b1;
      cpu_enable_r <= 1'b0;
      loading_r    <= 1'b0;
      overflow_r   <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
      csum_r       <= {NB_BYTE{1'b0}};
      chk_error_r  <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      instr_r      <= instr_s;
      count_r      <= count_s;
      we_r         <= we_s;
      cpu_reset_r  <= cpu_reset_s;
      cpu_enable_r <= cpu_enable_s;
      loading_r    <= loading_s;
      overflow_r   <= overflow_s;
`ifdef BIP_LOADER_CHECKSUM_EN
      csum_r       <= csum_s;
      chk_error_r  <= chk_error_s;
`endif
    end
  end

  assign o_pmem_addr  = addr_r;
  assign o_pmem_data  = instr_r;
  assign o_pmem_we    = we_r;
  assign o_cpu_reset  = cpu_reset_r;
  assign o_cpu_enable = cpu_enable_r;
  assign o_loading    = loading_r;
  assign o_overflow   = overflow_r;
  assign o_word_count = count_r;
`ifdef BIP_LOADER_CHECKSUM_EN
  assign o_chk_error  = chk_error_r;
`endif
endmodule

// File: tb/tb_bip_prog_loader.sv
// Self-checking bench for bip_prog_loader: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized loads.
module tb_bip_prog_loader;
  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] pmem_addr;
  logic [15:0] pmem_data;
  logic        pmem_we;
  logic        cpu_reset;
  logic        cpu_enable;
  logic        loading;
  logic        overflow;
  logic [11:0] word_count;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic        chk_error;
`endif

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [15:0] tb_mem [0:2047];

  bip_prog_loader dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_pmem_addr(pmem_addr), .o_pmem_data(pmem_data), .o_pmem_we(pmem_we),
    .o_cpu_reset(cpu_reset), .o_cpu_enable(cpu_enable), .o_loading(loading),
    .o_overflow(overflow), .o_word_count(word_count)
`ifdef BIP_LOADER_CHECKSUM_EN
    , .o_chk_error(chk_error)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory image as written by the DUT.
  always @(posedge clk) begin
    if (pmem_we) begin
      tb_mem[pmem_addr] <= pmem_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_idle, m_load, m_wr, m_done, m_chkwait, m_ovf, m_cerr;
  int         m_half, m_addr, m_count, m_age;
  logic [7:0] m_lo, m_csum;
  logic [15:0] m_word;

  task automatic model_reset();
    m_idle = 1; m_load = 0; m_wr = 0; m_done = 0; m_chkwait = 0; m_ovf = 0; m_cerr = 0;
    m_half = 0; m_addr = 0; m_count = 0; m_age = 0; m_lo = 8'h00; m_csum = 8'h00; m_word = 16'h0000;
  endtask

  task automatic model_start();
    m_idle = 0; m_done = 0; m_chkwait = 0; m_load = 1; m_half = 0;
    m_addr = 0; m_count = 0; m_ovf = 0; m_cerr = 0; m_csum = 8'h00;
  endtask

  task automatic model_finish();
    m_load = 0; m_done = 1; m_age = 0;
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d);
    if (!rst) begin
      model_reset();
    end else if (m_wr) begin
      m_wr = 0;
      if (m_word[15:11] == 5'd0) begin
`ifdef BIP_LOADER_CHECKSUM_EN
        m_load = 0; m_chkwait = 1;
`else
        model_finish();
`endif
      end else if (m_addr == 2047) begin
        m_ovf = 1; model_finish();
      end else begin
        m_addr++; m_half = 0;
      end
    end else if (m_idle || m_done) begin
      if (v && d == 8'h55) model_start();
      else if (m_done) m_age++;
    end else if (m_chkwait) begin
      if (v) begin
        m_cerr = (d != m_csum); m_chkwait = 0; model_finish();
      end
    end else if (v) begin
      m_csum ^= d;
      if (m_half == 0) begin
        m_lo = d; m_half = 1;
      end else begin
        m_word = {d, m_lo}; m_wr = 1; m_count++;
      end
    end
  endtask

  // Compare process: advance the model on each edge, check DUT outputs just after it.
  initial begin
    bit hold;
    model_reset();
    forever begin
      @(posedge clk);
      model_step(rst_n, rx_valid, rx_data);
      #1;
      hold = m_ovf || m_cerr;
      check("pmem_we", pmem_we, m_wr);
      if (m_wr) begin
        check("pmem_addr", pmem_addr, m_addr);
        check("pmem_data", pmem_data, m_word);
      end
      check("loading", loading, m_load);
      check("overflow", overflow, m_ovf);
      check("word_count", word_count, m_count);
      check("cpu_reset", cpu_reset, !(m_done && m_age >= 1 && !hold));
      check("cpu_enable", cpu_enable, m_done && m_age >= 2 && !hold);
`ifdef BIP_LOADER_CHECKSUM_EN
      check("chk_error", chk_error, m_cerr);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, pmem_addr, 32'd0);
    check({tag, "_data"}, pmem_data, 32'd0);
    check({tag, "_we"}, pmem_we, 32'd0);
    check({tag, "_cpu_reset"}, cpu_reset, 32'd1);
    check({tag, "_cpu_enable"}, cpu_enable, 32'd0);
    check({tag, "_loading"}, loading, 32'd0);
    check({tag, "_overflow"}, overflow, 32'd0);
    check({tag, "_count"}, word_count, 32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    check_reset_values("rst");
    rst_n = 1'b1;
    idle(1);

    // Basic load: 0x1234 then HLT; verify the release timing.
    base = wr_count;
    send_byte(8'h55); send_byte(8'h34); send_byte(8'h12); idle(1);
    send_byte(8'h00); send_byte(8'h00);
`ifdef BIP_LOADER_CHECKSUM_EN
    idle(1);
    send_byte(8'h26);
`else
    check("hlt_we", pmem_we, 32'd1);
    check("hlt_addr", pmem_addr, 32'd1);
    @(posedge clk); #1;
`endif
    check("done0_reset", cpu_reset, 32'd1);
    check("done0_enable", cpu_enable, 32'd0);
    @(posedge clk); #1;
    check("done1_reset", cpu_reset, 32'd0);
    check("done1_enable", cpu_enable, 32'd0);
    @(posedge clk); #1;
    check("done2_enable", cpu_enable, 32'd1);
    idle(2);
    check("basic_mem0", tb_mem[0], 32'h1234);
    check("basic_mem1", tb_mem[1], 32'h0000);
    check("basic_writes", wr_count - base, 32'd2);
    check("basic_count", word_count, 32'd2);

    // Reload from DONE.
    base = wr_count;
    send_byte(8'h55);
    check("reload_enable", cpu_enable, 32'd0);
    check("reload_reset", cpu_reset, 32'd1);
    check("reload_count", word_count, 32'd0);
    send_byte(8'hCD); send_byte(8'hAB);
    check("reload_addr", pmem_addr, 32'd0);
    check("reload_data", pmem_data, 32'hABCD);
    idle(1);
    send_byte(8'h00); send_byte(8'h00); idle(1);
`ifdef BIP_LOADER_CHECKSUM_EN
    send_byte(8'h67);
    idle(4);
    check("chk_err", chk_error, 32'd1);
    check("chk_held", cpu_reset, 32'd1);
`else
    idle(4);
    check("reload_run", cpu_enable, 32'd1);
`endif
    check("reload_writes", wr_count - base, 32'd2);

    // Non-start bytes in IDLE are ignored.
    do_reset();
    base = wr_count;
    send_byte(8'h12); idle(3);
    check("idle_loading", loading, 32'd0);
    send_byte(8'h55);
    check("idle_start", loading, 32'd1);

    // Asynchronous reset between the bytes of word 3.
    send_byte(8'h01); send_byte(8'h08); idle(1);
    send_byte(8'h02); send_byte(8'h08); idle(1);
    send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h55); send_byte(8'h77); send_byte(8'h10);
    check("restart_addr", pmem_addr, 32'd0);
    check("restart_we", pmem_we, 32'd1);
    idle(1);

    // Overflow: 2048 non-HLT words.
    do_reset();
    base = wr_count;
    send_byte(8'h55);
    for (int i = 0; i < 2048; i++) begin
      send_byte(8'h01); send_byte(8'h08); idle(1);
    end
    idle(4);
    check("ovf_writes", wr_count - base, 32'd2048);
    check("ovf_flag", overflow, 32'd1);
    check("ovf_reset", cpu_reset, 32'd1);
    check("ovf_enable", cpu_enable, 32'd0);
    check("ovf_count", word_count, 32'd2048);
    check("ovf_last", tb_mem[2047], 32'h0801);

    // Randomized loads with random gaps, embedded 0x55 data and reloads.
    for (int r = 0; r < 8; r++) begin
      int nw;
      logic [7:0] lo, hi;
      if ($urandom_range(0, 1) == 0) do_reset();
      send_byte(8'h55);
      nw = $urandom_range(1, 12);
      for (int w = 0; w < nw; w++) begin
        lo = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
        hi = {(w == nw - 1) ? 5'd0 : 5'($urandom_range(1, 31)), 3'($urandom)};
        send_byte(lo); idle($urandom_range(0, 2));
        send_byte(hi); idle($urandom_range(0, 2));
      end
`ifdef BIP_LOADER_CHECKSUM_EN
      idle(1);
      send_byte(($urandom_range(0, 1) == 0) ? m_csum : 8'($urandom));
`endif
      idle($urandom_range(2, 6));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
